// File: rtl/pingpang_dac_loader.sv
// Ping-pong DAC frame loader: the Pi fills one sample bank over GPIO while the other
// bank streams to the DAC; a completed frame takes over playback only at a waveform wrap.
module pingpang_dac_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter logic [11:0] IDLE_CODE = 12'h800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data_in,
  input  logic        r_cs_n_input,
  input  logic        r_dclk_input,
  input  logic        sample_en,
  output logic [11:0] dac_data,
  output logic        play_valid,
  output logic        busy,
  output logic        swap_done,
  output logic        overflow
);

  localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OneCnt   = (AW+1)'(1);
  localparam logic [AW-1:0] OneAddr  = AW'(1);

  // Bit 0 is s1, bit 2 is s3, bit 3 is the edge-detect flop.
  logic [3:0]  cs_sync_q, dclk_sync_q;
  logic [11:0] data_s1_q, data_s2_q, data_s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= 4'hf;
      dclk_sync_q <= 4'h0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      data_s3_q   <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[2:0], r_cs_n_input};
      dclk_sync_q <= {dclk_sync_q[2:0], r_dclk_input};
      data_s1_q   <= data_in;
      data_s2_q   <= data_s1_q;
      data_s3_q   <= data_s2_q;
    end
  end

  logic cs_s3, cs_fall, cs_rise, dclk_rise;
  assign cs_s3     = cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[2] & cs_sync_q[3];
  assign cs_rise   = cs_sync_q[2] & ~cs_sync_q[3];
  assign dclk_rise = dclk_sync_q[2] & ~dclk_sync_q[3];

  logic          play_bank_q, play_bank_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] play_addr_q, play_addr_d;
  logic [AW:0]   play_len_q, play_len_d;
  logic [AW:0]   pend_len_q, pend_len_d;
  logic          pending_q, pending_d;
  logic          play_valid_q, play_valid_d;
  logic          swap_done_q, swap_done_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic [11:0]   dac_q, dac_d;

  logic [11:0] mem_q [2*DEPTH];

  logic [AW:0] wr_idx;
  logic        wr_en, play_last, swap;

  // A dclk edge landing on the cs_fall cycle belongs to the new frame.
  assign wr_idx    = cs_fall ? '0 : wr_cnt_q;
  assign wr_en     = dclk_rise & ~cs_s3 & (wr_idx < DepthCnt);
  assign play_last = ({1'b0, play_addr_q} == (play_len_q - OneCnt));
  assign swap      = pending_q & (~play_valid_q | (sample_en & play_last));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{~play_bank_q, wr_idx[AW-1:0]}] <= data_s3_q;
    end
  end

  always_comb begin
    play_bank_d  = play_bank_q;
    wr_cnt_d     = wr_cnt_q;
    play_addr_d  = play_addr_q;
    play_len_d   = play_len_q;
    pend_len_d   = pend_len_q;
    pending_d    = pending_q;
    play_valid_d = play_valid_q;
    overflow_d   = overflow_q;
    dac_d        = dac_q;
    swap_done_d  = swap;
    busy_d       = ~cs_s3;

    if (sample_en && play_valid_q) begin
      dac_d       = mem_q[{play_bank_q, play_addr_q}];
      play_addr_d = play_last ? '0 : play_addr_q + OneAddr;
    end
    if (swap) begin
      play_bank_d  = ~play_bank_q;
      play_len_d   = pend_len_q;
      play_addr_d  = '0;
      play_valid_d = 1'b1;
      pending_d    = 1'b0;
    end
    if (cs_fall) begin
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
      pending_d  = 1'b0;
    end
    if (dclk_rise && !cs_s3) begin
      if (wr_en) wr_cnt_d = wr_idx + OneCnt;
      else       overflow_d = 1'b1;
    end
    // A new frame committing on the swap cycle must stay pending for the next wrap.
    if (cs_rise && (wr_cnt_q != '0)) begin
      pending_d  = 1'b1;
      pend_len_d = wr_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      play_bank_q  <= 1'b0;
      wr_cnt_q     <= '0;
      play_addr_q  <= '0;
      play_len_q   <= '0;
      pend_len_q   <= '0;
      pending_q    <= 1'b0;
      play_valid_q <= 1'b0;
      swap_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      dac_q        <= IDLE_CODE;
    end else begin
      play_bank_q  <= play_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      play_addr_q  <= play_addr_d;
      play_len_q   <= play_len_d;
      pend_len_q   <= pend_len_d;
      pending_q    <= pending_d;
      play_valid_q <= play_valid_d;
      swap_done_q  <= swap_done_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      dac_q        <= dac_d;
    end
  end

  assign dac_data   = dac_q;
  assign play_valid = play_valid_q;
  assign busy       = busy_q;
  assign swap_done  = swap_done_q;
  assign overflow   = overflow_q;

endmodule
